hog_result_reader: RTL

Readback engine on the result side of the HOG/image-scaling subsystem. After feature extraction it sweeps the four result BRAM banks through the `res_enb_0..3` / `res_addrb_0..3` read ports. It packs the four bank bytes read at each address into one 32-bit word and streams the words out with valid/ready flow control and a last marker. It is the read end of the result-bank interface; the HOG pipeline is the write end.

---
 rtl/hog_result_reader_pkg.sv | 23 ++
 rtl/hog_result_reader_fifo.sv | 53 +++++
 rtl/hog_result_reader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hog_result_reader_pkg.sv
// Shared definitions for the HOG result-bank readback engine: FSM encoding,
// bank packing order and the subsystem's default bank geometry.
package hog_result_reader_pkg;

    localparam int DEFAULT_RAM_AW = 17;
    localparam int DEFAULT_QN     = 8;
    localparam int NUM_BANKS      = 4;

    // Bank 0 occupies the least-significant byte lane of the packed word.
    localparam bit BANK0_IN_LSB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    function automatic int bank_lane(input int bank);
        return BANK0_IN_LSB ? bank : (NUM_BANKS - 1 - bank);
    endfunction

endpackage

// File: rtl/hog_result_reader_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head entry is
// visible on rd_data_o whenever empty_o is low.
module hog_res_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_rd;

    // Writers never exceed capacity, so no full check is applied on write.
    assign do_rd = rd_en_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(wr_en_i) - CW'(do_rd);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/hog_result_reader.sv
// Sweeps the four result BRAM banks, packs one byte per bank into a word and
// streams the words out with valid/ready flow control and a last marker.
module hog_result_reader
    import hog_result_reader_pkg::*;
#(
    parameter int RAM_AW     = DEFAULT_RAM_AW,
    parameter int QN         = DEFAULT_QN,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    arest_n,
    input  logic                    start,
    input  logic [RAM_AW-1:0]       base_addr,
    input  logic [RAM_AW:0]         rd_len,
    output logic                    res_enb,
    output logic [RAM_AW-1:0]       res_addrb,
    input  logic [QN-1:0]           res_doutb_0,
    input  logic [QN-1:0]           res_doutb_1,
    input  logic [QN-1:0]           res_doutb_2,
    input  logic [QN-1:0]           res_doutb_3,
    output logic [NUM_BANKS*QN-1:0] m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic                    done
);

    localparam int DW = NUM_BANKS * QN;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(RD_LAT + 1);

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [RAM_AW:0]   rem_q, rem_d;
    logic [RD_LAT-1:0] vld_q, last_q;
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              credit_ok;
    logic              issue, issue_last, capture, pop, out_last;
    logic [DW-1:0]     packed_data, out_data;
    logic [QN-1:0]     bank_data [NUM_BANKS];

    assign bank_data[0] = res_doutb_0;
    assign bank_data[1] = res_doutb_1;
    assign bank_data[2] = res_doutb_2;
    assign bank_data[3] = res_doutb_3;

    always_comb begin
        packed_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            packed_data[bank_lane(k)*QN +: QN] = bank_data[k];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + IW'(vld_q[i]);
        end
    end

    // Reserve a FIFO slot for every outstanding read so captured data always fits.
    assign credit_ok  = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    assign issue      = (state_q == ST_ISSUE) && credit_ok;
    assign issue_last = (rem_q == (RAM_AW+1)'(1));
    assign capture    = vld_q[RD_LAT-1];
    assign pop        = !fifo_empty && m_tready;

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    // The enable pipeline mirrors the bank read latency; its tail marks valid bank data.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            vld_q[0]  <= issue;
            last_q[0] <= issue && issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = rd_len;
                    state_d = (rd_len == '0) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + RAM_AW'(1);
                    rem_d  = rem_q - (RAM_AW+1)'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        res_enb   = issue;
        res_addrb = addr_q;
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        m_tvalid  = !fifo_empty;
        m_tdata   = out_data;
        m_tlast   = out_last;
    end

    hog_res_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (aclk),
        .rst_ni    (arest_n),
        .wr_en_i   (capture),
        .wr_data_i ({last_q[RD_LAT-1], packed_data}),
        .rd_en_i   (pop),
        .rd_data_o ({out_last, out_data}),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

endmodule
